// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and the digit-count helper for the binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  // Number of decimal digits needed to hold 2**bin_w - 1 (at least one digit).
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int              d;
    v = (64'd1 << bin_w) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'(BCD_ADJ_THRESH)) ? (i_dig + 4'(BCD_ADJ_ADD)) : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock; done pulses BIN_W edges after start.
// start is honoured only when idle; requests during a conversion are dropped. BIN2BCD_SIGNED_EN adds two's-complement input and sign_out.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BIN2BCD_SIGNED_EN
  localparam int NEED_DIGITS = min_digits(BIN_W - 1);
`else
  localparam int NEED_DIGITS = min_digits(BIN_W);
`endif

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W=%0d outside 1..32", BIN_W);
  end
  if (DIGITS < NEED_DIGITS) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d too small, need %0d", DIGITS, NEED_DIGITS);
  end

  state_t                   r_state;
  state_t                   w_next;
  logic [BIN_W-1:0]         r_shift;
  logic [SCR_W-1:0]         r_scr;
  logic [CNT_W-1:0]         r_cnt;
  logic [SCR_W-1:0]         r_bcd;
  logic [BIN_W-1:0]         w_mag;
  logic [SCR_W-1:0]         w_adj;
  logic [SCR_W+BIN_W-1:0]   w_cat;
  logic [SCR_W+BIN_W-1:0]   w_cat_sh;
  logic                     w_start_ok;
  logic                     w_last;

`ifdef BIN2BCD_SIGNED_EN
  logic r_sign_pend;
  logic r_sign;

  // Width-limited negate: the most negative input maps onto its unsigned magnitude.
  assign w_mag    = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
  assign sign_out = r_sign;
`else
  assign w_mag = bin_in;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_scr[4*g +: 4]),
      .o_dig (w_adj[4*g +: 4])
    );
  end

  assign w_cat    = {w_adj, r_shift};
  assign w_cat_sh = w_cat << 1;
  assign bcd_out  = r_bcd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    w_start_ok = 1'b0;
    w_last     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = SHIFT;
          w_start_ok = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next = DONE;
          w_last = 1'b1;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_scr       <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
`ifdef BIN2BCD_SIGNED_EN
      r_sign_pend <= 1'b0;
      r_sign      <= 1'b0;
`endif
    end else if (w_start_ok) begin
      r_shift     <= w_mag;
      r_scr       <= '0;
      r_cnt       <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
      r_sign_pend <= bin_in[BIN_W-1];
`endif
    end else if (r_state == SHIFT) begin
      r_scr   <= w_cat_sh[SCR_W+BIN_W-1 -: SCR_W];
      r_shift <= w_cat_sh[BIN_W-1:0];
      r_cnt   <= r_cnt - CNT_W'(1);
      // The final shift lands directly in the output so bcd_out and done line up.
      if (w_last) begin
        r_bcd <= w_cat_sh[SCR_W+BIN_W-1 -: SCR_W];
`ifdef BIN2BCD_SIGNED_EN
        r_sign <= r_sign_pend;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq at BIN_W=4/8/16, with signed vectors when BIN2BCD_SIGNED_EN is defined.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8, start16;
  logic [3:0]  bin4;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;
  logic [7:0]  bcd4;
  logic [11:0] bcd8;
  logic [19:0] bcd16;
`ifdef BIN2BCD_SIGNED_EN
  logic        sign4, sign8, sign16;
  localparam logic [31:0] E255 = 32'h001, E200 = 32'h056, E4 = 32'h05, E16 = 32'h00001;
`else
  localparam logic [31:0] E255 = 32'h255, E200 = 32'h200, E4 = 32'h11, E16 = 32'h65535;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sign4)
`endif
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sign8)
`endif
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin_in(bin16),
    .busy(busy16), .done(done16), .bcd_out(bcd16)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sign16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [31:0] v);
    case (which)
      4:       begin start4  = s; bin4  = v[3:0];  end
      8:       begin start8  = s; bin8  = v[7:0];  end
      default: begin start16 = s; bin16 = v[15:0]; end
    endcase
  endtask

  function automatic logic [31:0] get_bcd(input int which);
    case (which)
      4:       return {24'b0, bcd4};
      8:       return {20'b0, bcd8};
      default: return {12'b0, bcd16};
    endcase
  endfunction

  function automatic logic get_done(input int which);
    return (which == 4) ? done4 : (which == 8) ? done8 : done16;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 4) ? busy4 : (which == 8) ? busy8 : busy16;
  endfunction

  // One full conversion: latency, result, busy length, output hold and done width.
  task automatic conv(input int which, input logic [31:0] v, input logic [31:0] exp,
                      input int lat, input string tag);
    logic [31:0] prev;
    int          n;
    int          busy_n;
    logic        hold_bad;
    prev = get_bcd(which);
    @(negedge clk);
    drive(which, 1'b1, v);
    @(negedge clk);
    drive(which, 1'b0, ~v);
    n = 0;
    busy_n = 0;
    hold_bad = 1'b0;
    while (!get_done(which) && n < lat + 10) begin
      if (get_busy(which)) busy_n++;
      if (get_bcd(which) !== prev) hold_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".bcd"}, get_bcd(which), exp);
    chk({tag, ".busy_cycles"}, busy_n, lat);
    chk({tag, ".hold"}, {31'b0, hold_bad}, 32'd0);
    chk({tag, ".busy_at_done"}, {31'b0, get_busy(which)}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, {31'b0, get_done(which)}, 32'd0);
  endtask

  initial begin
    int          dones;
    int          n;
    logic [31:0] res;

    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    bin4 = '0; bin8 = '0; bin16 = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {31'b0, busy8}, 32'd0);
    chk("reset.done", {31'b0, done8}, 32'd0);
    chk("reset.bcd", {20'b0, bcd8}, 32'd0);
`ifdef BIN2BCD_SIGNED_EN
    chk("reset.sign", {31'b0, sign8}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    conv(8, 32'd11,  32'h011, 8, "u8_11");
    conv(8, 32'd255, E255,    8, "u8_255");
    conv(8, 32'd0,   32'h000, 8, "u8_0");

    // Second start three cycles into a conversion must be dropped.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    res = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        start8 = 1'b1; bin8 = 8'd99;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      if (done8) begin
        dones++;
        res = {20'b0, bcd8};
      end
    end
    chk("ignore.done_count", dones, 32'd1);
    chk("ignore.bcd", res, E200);

    // Reset at the 4th SHIFT cycle aborts the conversion without a done.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd77;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", {31'b0, busy8}, 32'd0);
    chk("abort.bcd", {20'b0, bcd8}, 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    chk("abort.no_done", dones, 32'd0);
    conv(8, 32'd42, 32'h042, 8, "u8_42");

    conv(4,  32'b1011,  E4,  4,  "w4_11");
    conv(16, 32'hFFFF,  E16, 16, "w16_max");

`ifdef BIN2BCD_SIGNED_EN
    conv(8, 32'd127, 32'h127, 8, "s8_127");
    chk("s8_127.sign", {31'b0, sign8}, 32'd0);
    // Sign must not change at start, only when the result lands.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0; bin8 = 8'h00;
    chk("s8_80.sign_hold", {31'b0, sign8}, 32'd0);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s8_80.latency", n, 32'd8);
    chk("s8_80.bcd", {20'b0, bcd8}, 32'h128);
    chk("s8_80.sign", {31'b0, sign8}, 32'd1);
    @(negedge clk);
    conv(8, 32'hF5, 32'h011, 8, "s8_F5");
    chk("s8_F5.sign", {31'b0, sign8}, 32'd1);
    chk("w4_neg.sign", {31'b0, sign4}, 32'd1);
    chk("w16_neg.sign", {31'b0, sign16}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
